// File: rtl/useq_lite.sv
// Microprogram address sequencer: selects the next PROM address from uPC, branch
// input, a small subroutine stack or a loop counter, driven by a 3-bit instruction.
module useq_lite #(
    parameter int AW    = 12,
    parameter int DEPTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    i,
    input  logic [AW-1:0] d,
    input  logic          cc_,
    input  logic          ccen_,
    output logic [AW-1:0] y,
    output logic          full_,
    output logic          empty_,
    output logic          zero_
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [2:0] {
        OP_JZ   = 3'd0,
        OP_CONT = 3'd1,
        OP_JMAP = 3'd2,
        OP_CJP  = 3'd3,
        OP_CJS  = 3'd4,
        OP_CRTN = 3'd5,
        OP_LDCT = 3'd6,
        OP_RPCT = 3'd7
    } op_e;

    logic [AW-1:0]  upc_q, upc_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  stack_q [DEPTH];

    logic           pass;
    logic           push;
    logic [AW-1:0]  tos;
    logic [AW-1:0]  y_w;
    logic [SPW-1:0] top_idx;
    logic [SPW-1:0] push_idx;

    // A disabled condition (ccen_ high) passes regardless of cc_.
    assign pass     = ccen_ | ~cc_;
    assign top_idx  = sp_q - 1'b1;
    assign tos      = (sp_q == '0) ? '0 : stack_q[top_idx];
    // A push onto a full stack lands on the top entry instead of growing it.
    assign push_idx = (sp_q == SP_FULL) ? (SP_FULL - 1'b1) : sp_q;

    always_comb begin
        y_w   = upc_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        push  = 1'b0;
        case (op_e'(i))
            OP_JZ: begin
                y_w  = '0;
                sp_d = '0;
            end
            OP_CONT: begin
                y_w = upc_q;
            end
            OP_JMAP: begin
                y_w = d;
            end
            OP_CJP: begin
                if (pass) y_w = d;
            end
            OP_CJS: begin
                if (pass) begin
                    y_w  = d;
                    push = 1'b1;
                    if (sp_q != SP_FULL) sp_d = sp_q + 1'b1;
                end
            end
            OP_CRTN: begin
                if (pass) begin
                    y_w = tos;
                    if (sp_q != '0) sp_d = sp_q - 1'b1;
                end
            end
            OP_LDCT: begin
                cnt_d = d;
            end
            OP_RPCT: begin
                if (cnt_q != '0) begin
                    y_w   = d;
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        if (rst) begin
            y_w  = '0;
            push = 1'b0;
        end
        upc_d = y_w + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upc_q <= AW'(1);
            cnt_q <= '0;
            sp_q  <= '0;
        end else begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
            sp_q  <= sp_d;
        end
    end

    // Stack storage carries no reset; only the pointer decides what is valid.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= upc_q;
    end

    assign y      = y_w;
    assign full_  = ~(sp_q == SP_FULL);
    assign empty_ = ~(sp_q == '0);
    assign zero_  = ~(cnt_q == '0);

endmodule

// File: tb/tb_useq_lite.sv
// Bench for useq_lite: directed program fragments followed by random instruction
// streams, all checked against a queue-based reference model.
module tb_useq_lite;

    localparam int AW    = 12;
    localparam int DEPTH = 5;

    logic          clk;
    logic          rst;
    logic [2:0]    i;
    logic [AW-1:0] d;
    logic          cc_;
    logic          ccen_;
    logic [AW-1:0] y;
    logic          full_;
    logic          empty_;
    logic          zero_;

    useq_lite #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .i     (i),
        .d     (d),
        .cc_   (cc_),
        .ccen_ (ccen_),
        .y     (y),
        .full_ (full_),
        .empty_(empty_),
        .zero_ (zero_)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    int m_upc;
    int m_cnt;
    int m_stk[$];
    bit known = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one instruction for one cycle, checks y/flags, advances the model.
    task automatic apply(input int ii, input int dd, input bit cc, input bit ccen, input bit r);
        int ey;
        bit ps;
        @(negedge clk);
        rst   = r;
        i     = ii[2:0];
        d     = dd[AW-1:0];
        cc_   = cc;
        ccen_ = ccen;
        #1;
        if (known) begin
            chk("full_",  int'(full_),  (m_stk.size() == DEPTH) ? 0 : 1);
            chk("empty_", int'(empty_), (m_stk.size() == 0) ? 0 : 1);
            chk("zero_",  int'(zero_),  (m_cnt == 0) ? 0 : 1);
        end
        ps = ccen | !cc;
        ey = m_upc;
        if (r) begin
            ey = 0;
            m_cnt = 0;
            m_stk.delete();
        end else begin
            case (ii)
                0: begin ey = 0; m_stk.delete(); end
                1: ey = m_upc;
                2: ey = dd;
                3: ey = ps ? dd : m_upc;
                4: if (ps) begin
                       ey = dd;
                       if (m_stk.size() == DEPTH) m_stk[DEPTH-1] = m_upc;
                       else m_stk.push_back(m_upc);
                   end
                5: if (ps) begin
                       if (m_stk.size() > 0) ey = m_stk.pop_back();
                       else ey = 0;
                   end
                6: m_cnt = dd;
                7: if (m_cnt != 0) begin ey = dd; m_cnt = m_cnt - 1; end
                default: ey = m_upc;
            endcase
        end
        if (r || known) chk("y", int'(y), ey);
        m_upc = r ? 1 : ((ey + 1) % (1 << AW));
        if (r) known = 1'b1;
    endtask

    localparam int JZ = 0, CONT = 1, JMAP = 2, CJP = 3, CJS = 4, CRTN = 5, LDCT = 6, RPCT = 7;

    initial begin
        rst = 1'b1; i = 3'd1; d = '0; cc_ = 1'b1; ccen_ = 1'b1;
        m_upc = 0; m_cnt = 0;

        // Reset, then sequential fetch
        apply(CONT, 0, 1, 1, 1);
        chk("rst_y", int'(y), 0);
        apply(CONT, 0, 1, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            apply(CONT, 0, 1, 1, 0);
            chk("cont_y", int'(y), k);
        end
        chk("rst_empty_", int'(empty_), 0);
        chk("rst_zero_",  int'(zero_),  0);

        // Conditional jump: fail, then pass
        apply(JMAP, 'h00F, 1, 1, 0);
        apply(CJP, 'h123, 1, 0, 0);
        chk("cjp_fail", int'(y), 'h010);
        apply(CJP, 'h123, 0, 0, 0);
        chk("cjp_pass", int'(y), 'h123);
        apply(CONT, 0, 1, 1, 0);
        chk("cjp_next", int'(y), 'h124);

        // Subroutine call/return, CJS fetched from 0x050
        apply(JMAP, 'h050, 1, 1, 0);
        apply(CJS, 'h200, 0, 0, 0);
        chk("cjs_y", int'(y), 'h200);
        apply(CONT, 0, 1, 1, 0);
        chk("sub_y1", int'(y), 'h201);
        chk("sub_empty_", int'(empty_), 1);
        apply(CONT, 0, 1, 1, 0);
        chk("sub_y2", int'(y), 'h202);
        apply(CRTN, 0, 0, 0, 0);
        chk("crtn_y", int'(y), 'h051);
        apply(CONT, 0, 1, 1, 0);
        chk("ret_empty_", int'(empty_), 0);

        // Stack overflow and underflow
        apply(JMAP, 'h100, 1, 1, 0);
        for (int k = 0; k < 6; k++) begin
            apply(CJS, 'h300 + k, 1, 1, 0);
            if (k == 5) chk("full_after5", int'(full_), 0);
        end
        for (int k = 0; k < 6; k++) begin
            apply(CRTN, 0, 1, 1, 0);
            if (k == 4) chk("pop5_y", int'(y), 'h101);
            if (k == 5) chk("pop6_y", int'(y), 0);
        end
        apply(CONT, 0, 1, 1, 0);
        chk("underflow_empty_", int'(empty_), 0);

        // Loop counter
        apply(LDCT, 3, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            apply(RPCT, 'h080, 1, 1, 0);
            if (k < 3) chk("rpct_loop", int'(y), 'h080);
            else begin
                chk("rpct_exit", int'(y), 'h081);
                chk("rpct_zero_", int'(zero_), 0);
            end
        end
        apply(CONT, 0, 1, 1, 0);
        chk("rpct_after", int'(y), 'h082);

        // Address wrap, then reset in the middle of a loop with a live stack entry
        apply(JMAP, 'hFFF, 1, 1, 0);
        chk("wrap_max", int'(y), 'hFFF);
        apply(CONT, 0, 1, 1, 0);
        chk("wrap_zero", int'(y), 0);
        apply(CJS, 'h040, 1, 1, 0);
        apply(LDCT, 5, 1, 1, 0);
        apply(RPCT, 'h040, 1, 1, 0);
        apply(RPCT, 'h040, 1, 1, 1);
        chk("rst_loop_y", int'(y), 0);
        apply(CONT, 0, 1, 1, 0);
        chk("post_rst_y", int'(y), 1);
        chk("post_rst_zero_", int'(zero_), 0);
        chk("post_rst_empty_", int'(empty_), 0);

        // Random instruction streams
        for (int k = 0; k < 600; k++) begin
            apply(int'($urandom_range(0, 7)), int'($urandom_range(0, (1 << AW) - 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
